// File: rtl/hilo_sequencer.sv
// hilo_sequencer: HI/LO multiply/divide sequencer (iterative shift-add multiply, restoring divide).
// Build option MULDIV_FAST_MULT_EN: MULT/MULTU finish in one cycle through a product register.

module hilo_sequencer (
    input  logic        clk,
    input  logic        reset_ni,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic        flush_i,
    input  logic        mf_req_i,
    output logic        busy_o,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIXUP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic [4:0]  count_r;
    logic        fix_phase_r;
    logic        is_div_r;
    logic        neg_lo_r;
    logic        neg_hi_r;
    logic        div_zero_r;
    logic [31:0] operand_r;
    logic [31:0] work_hi_r;
    logic [31:0] work_lo_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;
    logic        done_r;

    logic        accept_s;
    logic        is_mul_s;
    logic        is_div_s;
    logic        signed_op_s;
    logic        iter_start_s;
    logic [31:0] rs_mag_s;
    logic [31:0] rt_mag_s;
    logic [32:0] mul_sum_s;
    logic [32:0] div_shift_s;
    logic        div_ge_s;
    logic [31:0] div_rem_s;
    logic [63:0] prod_neg_s;
    logic [31:0] fix_hi_s;
    logic [31:0] fix_lo_s;

    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic is_signed);
        if (is_signed && value[31]) begin
            return 32'd0 - value;
        end else begin
            return value;
        end
    endfunction

    assign is_mul_s    = (op_i == OP_MULT) || (op_i == OP_MULTU);
    assign is_div_s    = (op_i == OP_DIV)  || (op_i == OP_DIVU);
    assign signed_op_s = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign accept_s    = start_i && !flush_i && (state_r == ST_IDLE);
    assign rs_mag_s    = magnitude(rs_i, signed_op_s);
    assign rt_mag_s    = magnitude(rt_i, signed_op_s);

`ifdef MULDIV_FAST_MULT_EN
    assign iter_start_s = accept_s && is_div_s;

    logic        fast_start_s;
    logic [63:0] fast_prod_s;
    logic        fast_pend_r;
    logic [63:0] fast_prod_r;

    // Sign-extending both operands makes the low 64 bits correct for signed and unsigned alike
    assign fast_start_s = accept_s && is_mul_s;
    assign fast_prod_s  = {{32{signed_op_s & rs_i[31]}}, rs_i} * {{32{signed_op_s & rt_i[31]}}, rt_i};

    // One-stage product register feeding the HI/LO write one edge after acceptance
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            fast_pend_r <= 1'b0;
            fast_prod_r <= 64'd0;
        end else begin
            fast_pend_r <= fast_start_s;
            if (fast_start_s) begin
                fast_prod_r <= fast_prod_s;
            end else begin
                fast_prod_r <= fast_prod_r;
            end
        end
    end
`else
    assign iter_start_s = accept_s && (is_mul_s || is_div_s);
`endif

    // One iteration step: multiply adds into the upper half, divide trial-subtracts the divisor
    assign mul_sum_s   = {1'b0, work_hi_r} + (work_lo_r[0] ? {1'b0, operand_r} : 33'd0);
    assign div_shift_s = {work_hi_r, work_lo_r[31]};
    assign div_ge_s    = (div_shift_s >= {1'b0, operand_r});
    assign div_rem_s   = div_shift_s[31:0] - operand_r;

    // Sign correction of the unsigned iteration result
    always_comb begin
        prod_neg_s = 64'd0 - {work_hi_r, work_lo_r};
        fix_hi_s   = work_hi_r;
        fix_lo_s   = work_lo_r;
        if (!is_div_r) begin
            if (neg_lo_r) begin
                fix_hi_s = prod_neg_s[63:32];
                fix_lo_s = prod_neg_s[31:0];
            end else begin
                fix_hi_s = work_hi_r;
                fix_lo_s = work_lo_r;
            end
        end else if (div_zero_r) begin
            fix_hi_s = 32'd0;
            fix_lo_s = 32'd0;
        end else begin
            fix_lo_s = neg_lo_r ? (32'd0 - work_lo_r) : work_lo_r;
            fix_hi_s = neg_hi_r ? (32'd0 - work_hi_r) : work_hi_r;
        end
    end

    // Next-state logic; flush wins over everything else
    always_comb begin
        state_nx_s = state_r;
        if (flush_i) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (iter_start_s) begin
                        state_nx_s = ST_RUN;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (count_r == 5'd0) begin
                        state_nx_s = ST_FIXUP;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end
                ST_FIXUP: begin
                    if (fix_phase_r) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_FIXUP;
                    end
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath: operand latch, iteration, two-cycle FIXUP (correct, then commit) and HI/LO writes
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            count_r     <= 5'd0;
            fix_phase_r <= 1'b0;
            is_div_r    <= 1'b0;
            neg_lo_r    <= 1'b0;
            neg_hi_r    <= 1'b0;
            div_zero_r  <= 1'b0;
            operand_r   <= 32'd0;
            work_hi_r   <= 32'd0;
            work_lo_r   <= 32'd0;
            hi_r        <= 32'd0;
            lo_r        <= 32'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            busy_r <= (state_nx_s != ST_IDLE);
`ifdef MULDIV_FAST_MULT_EN
            if (fast_pend_r && !flush_i) begin
                hi_r   <= fast_prod_r[63:32];
                lo_r   <= fast_prod_r[31:0];
                done_r <= 1'b1;
            end
`endif
            if (flush_i) begin
                count_r     <= 5'd0;
                fix_phase_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (iter_start_s) begin
                            is_div_r    <= is_div_s;
                            neg_lo_r    <= signed_op_s && (rs_i[31] ^ rt_i[31]);
                            neg_hi_r    <= signed_op_s && rs_i[31];
                            div_zero_r  <= (rt_i == 32'd0);
                            work_hi_r   <= 32'd0;
                            operand_r   <= is_div_s ? rt_mag_s : rs_mag_s;
                            work_lo_r   <= is_div_s ? rs_mag_s : rt_mag_s;
                            count_r     <= 5'd31;
                            fix_phase_r <= 1'b0;
                        end else if (accept_s && (op_i == OP_MTHI)) begin
                            hi_r <= rs_i;
                        end else if (accept_s && (op_i == OP_MTLO)) begin
                            lo_r <= rs_i;
                        end
                    end
                    ST_RUN: begin
                        if (is_div_r) begin
                            work_hi_r <= div_ge_s ? div_rem_s : div_shift_s[31:0];
                            work_lo_r <= {work_lo_r[30:0], div_ge_s};
                        end else begin
                            {work_hi_r, work_lo_r} <= {mul_sum_s, work_lo_r[31:1]};
                        end
                        if (count_r != 5'd0) begin
                            count_r <= count_r - 5'd1;
                        end
                    end
                    ST_FIXUP: begin
                        if (!fix_phase_r) begin
                            work_hi_r   <= fix_hi_s;
                            work_lo_r   <= fix_lo_s;
                            fix_phase_r <= 1'b1;
                        end else begin
                            hi_r        <= work_hi_r;
                            lo_r        <= work_lo_r;
                            done_r      <= 1'b1;
                            fix_phase_r <= 1'b0;
                        end
                    end
                    default: begin
                        count_r     <= 5'd0;
                        fix_phase_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy_o  = busy_r;
    assign done_o  = done_r;
    assign hi_o    = hi_r;
    assign lo_o    = lo_r;
    assign stall_o = mf_req_i & busy_r;

endmodule

// File: tb/tb_hilo_sequencer.sv
// Bench for hilo_sequencer: cycle-level arithmetic model checked every cycle, plus literal result/latency checks.

module tb_hilo_sequencer;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] rs_i;
    logic [31:0] rt_i;
    logic        flush_i;
    logic        mf_req_i;
    logic        busy_o;
    logic        stall_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif

    hilo_sequencer dut (
        .clk      (clk),
        .reset_ni (reset_ni),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs_i     (rs_i),
        .rt_i     (rt_i),
        .flush_i  (flush_i),
        .mf_req_i (mf_req_i),
        .busy_o   (busy_o),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, straight from the arithmetic definition
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'd0;
        case (op)
            3'd0: p = 64'(sa * sb);
            3'd1: p = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b != 32'd0) begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (b != 32'd0) p = {a % b, a / b};
            end
            default: p = 64'd0;
        endcase
        return p;
    endfunction

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_res_hi = 32'd0;
    logic [31:0] m_res_lo = 32'd0;
    int          m_left = 0;

    // Model: an accepted op writes its result a fixed number of edges later
    always @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (flush_i) begin
                m_left <= 0;
                m_busy <= 1'b0;
            end else if (m_left != 0) begin
                if (m_left == 1) begin
                    m_hi   <= m_res_hi;
                    m_lo   <= m_res_lo;
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end
                m_left <= m_left - 1;
            end else if (start_i) begin
                if (op_i == 3'd4) begin
                    m_hi <= rs_i;
                end else if (op_i == 3'd5) begin
                    m_lo <= rs_i;
                end else if (op_i < 3'd4) begin
                    {m_res_hi, m_res_lo} <= ref_result(op_i, rs_i, rt_i);
                    if (op_i < 3'd2 && MUL_LAT == 1) begin
                        m_left <= 1;
                    end else begin
                        m_left <= 34;
                        m_busy <= 1'b1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy",  64'(busy_o),  64'(m_busy));
            chk("cyc_done",  64'(done_o),  64'(m_done));
            chk("cyc_hi",    64'(hi_o),    64'(m_hi));
            chk("cyc_lo",    64'(lo_o),    64'(m_lo));
            chk("cyc_stall", 64'(stall_o), 64'(mf_req_i & m_busy));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start_i = 1'b1;
        op_i    = op;
        rs_i    = a;
        rt_i    = b;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [31:0] eh, input logic [31:0] el, input int elat);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        for (int i = 1; i <= 100 && !seen; i++) begin
            tick();
            if (done_o) begin
                seen = 1'b1;
                n = i;
            end
        end
        chk({name, "_done"}, 64'(seen), 64'd1);
        chk({name, "_lat"},  64'(n),    64'(elat));
        chk({name, "_hi"},   64'(hi_o), 64'(eh));
        chk({name, "_lo"},   64'(lo_o), 64'(el));
    endtask

    task automatic count_done(input string name, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done_o) pulses++;
        end
        chk(name, 64'(pulses), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st, lat;
        bit seen;
        reset_ni = 1'b0;
        start_i  = 1'b0;
        op_i     = 3'd0;
        rs_i     = 32'd0;
        rt_i     = 32'd0;
        flush_i  = 1'b0;
        mf_req_i = 1'b1;
        tick();
        cmp_en = 1'b1;
        tick();
        chk("rst_busy",  64'(busy_o),  64'd0);
        chk("rst_done",  64'(done_o),  64'd0);
        chk("rst_hi",    64'(hi_o),    64'd0);
        chk("rst_lo",    64'(lo_o),    64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        mf_req_i = 1'b0;

        // First start right after reset release
        reset_ni = 1'b1;
        issue(3'd0, 32'hFFFF_FFFF, 32'd2);
        chk("mult_busy_e0", 64'(busy_o), (MUL_LAT == 1) ? 64'd0 : 64'd1);
        wait_done("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);

        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        wait_done("multu", 32'h0000_0001, 32'hFFFF_FFFE, MUL_LAT);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);

        // DIVU with an MTHI attempt mid-run that must be dropped
        issue(3'd3, 32'd100, 32'd7);
        repeat (4) tick();
        issue(3'd4, 32'h0000_AAAA, 32'd0);
        wait_done("divu", 32'd2, 32'd14, 29);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 32'd0, 32'h8000_0000, 34);

        // Reserved opcode changes nothing
        issue(3'd6, 32'd1, 32'd2);
        chk("op6_busy", 64'(busy_o), 64'd0);
        chk("op6_lo",   64'(lo_o),   64'h8000_0000);

        issue(3'd0, 32'h8000_0000, 32'h8000_0000);
        wait_done("mult_min", 32'h4000_0000, 32'd0, MUL_LAT);
        issue(3'd2, 32'd7, 32'hFFFF_FFFE);
        wait_done("div_negdiv", 32'd1, 32'hFFFF_FFFD, 34);
        issue(3'd3, 32'hFFFF_FFFF, 32'd10);
        wait_done("divu_big", 32'd5, 32'h1999_9999, 34);

        // Divide by zero with the pipeline reading HI/LO throughout
        issue(3'd5, 32'hDEAD_BEEF, 32'd0);
        chk("mtlo", 64'(lo_o), 64'hDEAD_BEEF);
        mf_req_i = 1'b1;
        issue(3'd3, 32'd5, 32'd0);
        st = 0;
        lat = 0;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            if (done_o) begin
                seen = 1'b1;
                lat = k;
            end else begin
                if (stall_o) st++;
                tick();
            end
        end
        chk("dz_done",  64'(seen),    64'd1);
        chk("dz_lat",   64'(lat),     64'd34);
        chk("dz_stall", 64'(st),      64'd34);
        chk("dz_after", 64'(stall_o), 64'd0);
        chk("dz_hi",    64'(hi_o),    64'd0);
        chk("dz_lo",    64'(lo_o),    64'd0);
        mf_req_i = 1'b0;

        // Flush mid-divide, then flush beating a simultaneous start
        issue(3'd4, 32'h1234_5678, 32'd0);
        issue(3'd2, 32'd100, 32'd3);
        repeat (9) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_busy", 64'(busy_o), 64'd0);
        issue(3'd5, 32'h0000_0055, 32'd0);
        chk("flush_next_lo", 64'(lo_o), 64'h55);
        chk("flush_hi",      64'(hi_o), 64'h1234_5678);
        flush_i = 1'b1;
        issue(3'd4, 32'hFFFF_0000, 32'd0);
        flush_i = 1'b0;
        chk("flush_vs_start", 64'(hi_o), 64'h1234_5678);
        count_done("flush_no_done", 40);

        // Asynchronous reset in the middle of RUN
        issue(3'd4, 32'h0000_CAFE, 32'd0);
        issue(3'd5, 32'h0000_F00D, 32'd0);
        issue(3'd3, 32'd15, 32'd4);
        repeat (5) tick();
        #2;
        reset_ni = 1'b0;
        #1;
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_done", 64'(done_o), 64'd0);
        chk("arst_hi",   64'(hi_o),   64'd0);
        chk("arst_lo",   64'(lo_o),   64'd0);
        tick();
        reset_ni = 1'b1;
        count_done("arst_no_done", 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hilo_sequencer.md
HILO_SEQUENCER -- requirements
Module: hilo_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_ni, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port start_i, input, 1 bit: issue the operation on op_i this cycle.
REQ-004 SHALL have port op_i, input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are ignored.
REQ-005 SHALL have ports rs_i and rt_i, input, 32 bits each: source operands; dividend is rs_i, divisor is rt_i.
REQ-006 SHALL have port flush_i, input, 1 bit: abort any in-flight operation.
REQ-007 SHALL have port mf_req_i, input, 1 bit: the pipeline is reading HI/LO (MFHI/MFLO) this cycle.
REQ-008 SHALL have port busy_o, output, 1 bit: a multi-cycle operation is in flight.
REQ-009 SHALL have port stall_o, output, 1 bit: combinational, equal to mf_req_i AND busy_o.
REQ-010 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have ports hi_o and lo_o, output, 32 bits each: architectural HI and LO registers.

Function
REQ-012 SHALL implement the state machine IDLE -> RUN -> FIXUP -> IDLE.
REQ-013 SHALL accept start_i only in IDLE; start_i in RUN or FIXUP SHALL be ignored, with no queueing.
REQ-014 MTHI/MTLO accepted in IDLE SHALL write rs_i to HI/LO at the next edge, stay in IDLE, and assert neither busy_o nor done_o.
REQ-015 A MULT/MULTU/DIV/DIVU start accepted at edge E0 SHALL enter RUN, latch operand magnitudes and sign flags, and load a 5-bit counter with 31.
REQ-016 RUN SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, decrement the counter, and move to FIXUP after the step at count 0 (32 steps).
REQ-017 FIXUP SHALL apply sign correction and write HI/LO at its closing edge, E0+34, then return to IDLE.
REQ-018 busy_o SHALL be 1 from the cycle after E0 through the FIXUP cycle, and 0 otherwise.
REQ-019 done_o SHALL be 1 for exactly the cycle after the HI/LO write, the same cycle new hi_o/lo_o first appear.
REQ-020 MULT/MULTU SHALL write the 64-bit signed/unsigned product, with HI = product[63:32] and LO = product[31:0].
REQ-021 DIV SHALL produce LO = quotient truncated toward zero and HI = remainder carrying the dividend's sign.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL produce LO = 0x80000000 and HI = 0.
REQ-023 DIV/DIVU with rt_i = 0 SHALL still take the full 34 cycles and SHALL write HI = 0 and LO = 0.
REQ-024 flush_i SHALL return the machine to IDLE at the next edge with no HI/LO write and no done_o; flush_i outranks start_i in the same cycle.
REQ-025 hi_o/lo_o SHALL hold their old values throughout RUN and FIXUP.

Reset
REQ-026 Asserting reset_ni low SHALL immediately force state = IDLE, counter = 0, hi_o = 0, lo_o = 0, busy_o = 0, done_o = 0, including mid-operation.
REQ-027 After reset_ni deasserts, the first start_i SHALL be accepted on the first rising edge.

Configuration
REQ-028 With MULDIV_FAST_MULT_EN defined, MULT/MULTU SHALL complete in one cycle: HI/LO written at E0+1, busy_o never asserted, done_o high in the cycle after E0+1.
REQ-029 With MULDIV_FAST_MULT_EN defined, DIV/DIVU SHALL remain iterative exactly as in REQ-015..REQ-019.
REQ-030 Without MULDIV_FAST_MULT_EN, all four operations SHALL use the 34-cycle iterative path.

Verification
REQ-031 MULT with rs = 0xFFFFFFFF, rt = 2 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFFE; done_o at E0+34 without the macro, at E0+1 with it.
REQ-032 MULTU with rs = 0xFFFFFFFF, rt = 2 -> HI = 0x00000001, LO = 0xFFFFFFFE.
REQ-033 DIV with rs = 0xFFFFFFF9 (-7), rt = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIVU with rs = 100, rt = 7 -> LO = 14, HI = 2.
REQ-034 DIVU with rs = 5, rt = 0 -> HI = LO = 0 after 34 cycles; mf_req_i held high during the operation -> stall_o = 1 until done_o.
REQ-035 MTHI 0x12345678, then DIV started and flushed at cycle 10 -> hi_o stays 0x12345678, no done_o pulse, and a new start is accepted the next cycle.
REQ-036 reset_ni pulsed low mid-RUN -> all outputs go to 0 asynchronously, with no done_o pulse.
